// File: rtl/md5_pkg.sv
// Shared MD5 constants: round K table, per-round rotate amounts, FSM states
// and the standard initial chaining value.
package md5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  localparam int unsigned NUM_ROUNDS = 64;

  // {D,C,B,A}, A in the low word
  localparam logic [127:0] MD5_IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};

  localparam logic [31:0] K_TAB [NUM_ROUNDS] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S_TAB [NUM_ROUNDS] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

endpackage

// File: rtl/md5_round_step.sv
// One combinational MD5 round: picks F, message index, K and rotate by round
// number and produces the rotated working registers.
module md5_round_step
  import md5_pkg::*;
(
  input  logic [31:0]  a_i,
  input  logic [31:0]  b_i,
  input  logic [31:0]  c_i,
  input  logic [31:0]  d_i,
  input  logic [5:0]   round_i,
  input  logic [511:0] message_i,
  output logic [31:0]  a_o,
  output logic [31:0]  b_o,
  output logic [31:0]  c_o,
  output logic [31:0]  d_o
);

  logic [7:0]  r8;
  logic [7:0]  gx;
  logic [3:0]  g;
  logic [31:0] f;
  logic [31:0] m_word;
  logic [31:0] sum;
  logic [31:0] rot;
  logic [4:0]  s;

  assign r8 = {2'b00, round_i};

  always_comb begin
    f  = '0;
    gx = '0;
    unique case (round_i[5:4])
      2'd0: begin f = (b_i & c_i) | (~b_i & d_i); gx = r8;                 end
      2'd1: begin f = (d_i & b_i) | (~d_i & c_i); gx = r8 * 8'd5 + 8'd1;   end
      2'd2: begin f = b_i ^ c_i ^ d_i;            gx = r8 * 8'd3 + 8'd5;   end
      default: begin f = c_i ^ (b_i | ~d_i);      gx = r8 * 8'd7;          end
    endcase
  end

  // Only the low nibble matters: the index is taken mod 16.
  assign g      = gx[3:0];
  assign m_word = message_i[{g, 5'b00000} +: 32];
  assign s      = S_TAB[round_i];
  assign sum    = a_i + f + K_TAB[round_i] + m_word;
  // s is never 0, so the right shift by 32-s stays in range.
  assign rot    = (sum << s) | (sum >> (6'd32 - {1'b0, s}));

  assign a_o = d_i;
  assign b_o = b_i + rot;
  assign c_o = b_i;
  assign d_o = c_i;

endmodule

// File: rtl/md5_block_sequencer.sv
// Runs one 512-bit block through 64 MD5 rounds, one per clock, then folds in
// the chaining value and pulses done.
module md5_block_sequencer
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] message,
  input  logic [127:0] hash_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] hash_out
);

  state_e       state_q, state_d;
  logic [5:0]   round_q;
  logic [511:0] msg_q;
  logic [127:0] h0_q;
  logic [31:0]  a_q, b_q, c_q, d_q;
  logic [31:0]  a_d, b_d, c_d, d_d;
  logic [127:0] hash_q;
  logic         done_q;
  logic         accept;
  logic         finish;

  assign accept = (state_q == ST_IDLE) && start;
  assign finish = (state_q == ST_FINAL) && !abort;

  md5_round_step u_step (
    .a_i       (a_q),
    .b_i       (b_q),
    .c_i       (c_q),
    .d_i       (d_q),
    .round_i   (round_q),
    .message_i (msg_q),
    .a_o       (a_d),
    .b_o       (b_d),
    .c_o       (c_d),
    .d_o       (d_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_ROUND;
      ST_ROUND: begin
        if (abort)                 state_d = ST_IDLE;
        else if (round_q == 6'd63) state_d = ST_FINAL;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q <= '0;
      msg_q   <= '0;
      h0_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else if (accept) begin
      round_q <= '0;
      msg_q   <= message;
      h0_q    <= hash_in;
      a_q     <= hash_in[31:0];
      b_q     <= hash_in[63:32];
      c_q     <= hash_in[95:64];
      d_q     <= hash_in[127:96];
    end else if (state_q == ST_ROUND && !abort) begin
      round_q <= round_q + 6'd1;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        hash_q <= {h0_q[127:96] + d_q, h0_q[95:64] + c_q,
                   h0_q[63:32]  + b_q, h0_q[31:0]  + a_q};
      end
    end
  end

  assign done     = done_q;
  assign hash_out = hash_q;

endmodule

// File: tb/tb_md5_block_sequencer.sv
// Directed bench for md5_block_sequencer: known digests via a scoreboard queue,
// latency, back-to-back, ignored start, abort and async reset.
module tb_md5_block_sequencer;

  localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
  localparam logic [127:0] DIG_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
  localparam logic [127:0] DIG_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [511:0] message = '0;
  logic [127:0] hash_in = '0;
  logic         busy;
  logic         done;
  logic [127:0] hash_out;

  logic [511:0] msg_empty;
  logic [511:0] msg_abc;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  md5_block_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .message  (message),
    .hash_in  (hash_in),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs;
    for (int i = 0; i < 16; i++) message[i*32 +: 32] = $urandom;
    hash_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Drives one accept edge; inputs are scrambled afterwards to prove capture.
  task automatic start_block(input logic [511:0] msg, input logic [127:0] dig);
    message = msg;
    hash_in = IV;
    start   = 1'b1;
    exp_q.push_back(dig);
    tick();
    start = 1'b0;
    scramble_inputs();
  endtask

  // n0 = clock edges already seen since the accept edge.
  task automatic wait_done(input string tag, input int n0, input int lat_exp);
    int n = n0;
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    logic [127:0] dig;
    while (n < 200 && !seen) begin
      tick();
      n++;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk({tag, "_done_seen"}, 128'(seen), 128'd1);
    chk({tag, "_latency"}, 128'(n), 128'(lat_exp));
    chk({tag, "_busy_high"}, 128'(busy_ok), 128'd1);
    chk({tag, "_busy_in_done"}, 128'(busy), 128'd0);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_scoreboard observed=%h expected=<none queued>", tag, hash_out);
    end else begin
      dig = exp_q.pop_front();
      chk({tag, "_digest"}, hash_out, dig);
    end
  endtask

  task automatic count_idle_dones(input string tag, input int cycles);
    int nd = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) nd++;
    end
    chk({tag, "_no_done"}, 128'(nd), 128'd0);
  endtask

  initial begin
    msg_empty = '0;
    msg_empty[31:0] = 32'h00000080;
    msg_abc = '0;
    msg_abc[31:0] = 32'h80636261;
    msg_abc[14*32 +: 32] = 32'h00000018;

    // reset state
    tick();
    tick();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_hash", hash_out, 128'd0);
    rst_n = 1'b1;
    tick();

    // empty-string block
    start_block(msg_empty, DIG_EMPTY);
    wait_done("empty", 0, 65);
    tick();
    chk("empty_done_pulse", 128'(done), 128'd0);
    chk("empty_hash_held", hash_out, DIG_EMPTY);

    // back-to-back: start held high through the first block and its done cycle
    message = msg_abc;
    hash_in = IV;
    start   = 1'b1;
    exp_q.push_back(DIG_ABC);
    tick();
    wait_done("b2b1", 0, 65);
    message = msg_empty;
    hash_in = IV;
    exp_q.push_back(DIG_EMPTY);
    tick();
    start = 1'b0;
    scramble_inputs();
    chk("b2b_done_pulse", 128'(done), 128'd0);
    chk("b2b_busy_after_accept", 128'(busy), 128'd1);
    chk("b2b_hash_held", hash_out, DIG_ABC);
    wait_done("b2b2", 1, 66);

    // start while busy at round 30 is ignored
    start_block(msg_abc, DIG_ABC);
    for (int i = 0; i < 30; i++) tick();
    message = msg_empty;
    hash_in = IV;
    start   = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start", 31, 65);
    count_idle_dones("busy_start", 80);

    // abort at round 40
    start_block(msg_empty, DIG_EMPTY);
    for (int i = 0; i < 40; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_hash", hash_out, DIG_ABC);
    count_idle_dones("abort", 80);
    chk("abort_hash_later", hash_out, DIG_ABC);
    start_block(msg_abc, DIG_ABC);
    wait_done("post_abort", 0, 65);

    // async reset at round 10, checked before any further clock edge
    start_block(msg_empty, DIG_EMPTY);
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", 128'(busy), 128'd0);
    chk("areset_done", 128'(done), 128'd0);
    chk("areset_hash", hash_out, 128'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("areset_idle", 128'(busy), 128'd0);
    start_block(msg_empty, DIG_EMPTY);
    wait_done("post_reset", 0, 65);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md5_block_sequencer.md
# md5_block_sequencer

Sequential controller that runs one 512-bit MD5 block through all 64 rounds, one round per clock, and adds the chaining value at the end. Sits between the message-scheduling/padding logic and the combinational round-type datapaths. It owns the round counter, selects the round function, K constant, shift amount and message word, and presents the updated 128-bit chaining value with a one-cycle `done` pulse.

## Interface
- No parameters. Round count (64), K table and shift table are fixed constants.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request to hash one block; sampled only in IDLE.
- `abort` in 1: cancel the block in progress; return to IDLE without `done`.
- `message` in 512: block words, word i at bits [32i+31:32i]; captured on start accept.
- `hash_in` in 128: chaining value {D,C,B,A}, with A at [31:0]; captured on start accept.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when `hash_out` is updated.
- `hash_out` out 128: result {D,C,B,A}; held until the next `done`.

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE: if `start`=1, latch `message` and `hash_in` into the block and initial-value registers, load working regs a,b,c,d from `hash_in`, set round=0, and go to ROUND. Otherwise stay.
- ROUND, per cycle for round r = 0..63:
  - Function and message index by phase:
    - r/16=0: F=(b&c)|(~b&d), g=r
    - r/16=1: F=(d&b)|(~d&c), g=(5r+1) mod 16
    - r/16=2: F=b^c^d, g=(3r+5) mod 16
    - r/16=3: F=c^(b|~d), g=7r mod 16
  - Update: a'=d, d'=c, c'=b, b'=b+rotl32(a+F+K[r]+M[g], s[r]).
  - All additions are modulo 2^32. Carries are discarded.
  - round increments. After r=63 is processed, go to FINAL.
- FINAL: hash_out = {D0+d, C0+c, B0+b, A0+a}, each add mod 2^32. Pulse `done`, go to IDLE.
- `abort` (any non-IDLE state): next state is IDLE. No `done`, `hash_out` unchanged. `abort` has priority over FINAL.
- `start` while busy: ignored, not queued.
- `start` and `abort` both high in IDLE: `start` wins.
- `message`/`hash_in` may change freely after the accept edge.

## Timing
- Reset values: state=IDLE, round=0, busy=0, done=0, hash_out=0, working and latched registers=0.
- Reset asserted mid-block: immediate return to IDLE and all outputs cleared. No `done`.
- Accept edge E0 takes state to ROUND. Edges E1..E64 perform rounds 0..63. Edge E65 (leaving FINAL) updates `hash_out` and raises `done`.
- `done` is high for exactly the one cycle after E65. Total latency from accept edge to `done` is 65 cycles.
- `busy` is high from E0 until E65, i.e. 65 cycles, and low during the `done` cycle.
- Back-to-back: `start` high during the `done` cycle is accepted, giving one block every 66 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package `md5_pkg` holds:
  - the 64-entry K table;
  - the 64-entry shift table (7,12,17,22 / 5,9,14,20 / 4,11,16,23 / 6,10,15,21);
  - the state enum;
  - a localparam for the MD5 initial value 67452301/efcdab89/98badcfe/10325476.
- One combinational sub-module, `md5_round_step`:
  - inputs a,b,c,d, round index and the 512-bit message;
  - outputs a',b',c',d';
  - internally selects among the four round-type functions.
- The sequencer holds state, counter and registers only.

## Test plan
- Empty string: padded block with word0=00000080, all other words 0, and `hash_in` = MD5 IV. Required: `done` 65 cycles after accept; hash_out[31:0]=d98c1dd4, [63:32]=04b2008f, [95:64]=980980e9, [127:96]=7e42f8ec.
- "abc": word0=80636261, word14=00000018, other words 0, IV as above. Required: A=98500190, B=b04fd23c, C=7d3f96d6, D=727fe128.
- Back-to-back: run "abc" and hold `start` high through its `done` cycle, then change inputs to the empty-string block. Required: second `done` exactly 66 cycles after the first, with the empty-string digest; busy low only in the `done` cycles.
- Start while busy: pulse `start` with different data at round 30. Required: ignored; first result unchanged; no extra `done`.
- Abort at round 40: `busy` low the next cycle, no `done`, `hash_out` still holds the prior digest. A following "abc" start yields the correct digest.
- Async reset at round 10: outputs go to 0 immediately without a clock edge. After `rst_n` deasserts, the empty-string block completes correctly.
